// File: rtl/jtobj_scan.sv
// Per-line sprite table scanner: fetches each object entry, tests it against the
// rendered line, and issues one drawer request per 16-pixel tile. JTOBJ_SCAN_LIMIT_EN adds a per-line sprite budget.
module jtobj_scan #(
    parameter int OBJW   = 8,
    parameter int MAXSPR = 32,
    parameter int ZFRAC  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            line_start,
    input  logic [8:0]      vrender,
    output logic [OBJW+1:0] tbl_addr,
    input  logic [15:0]     tbl_data,
    output logic [15:0]     code,
    output logic [8:0]      attr,
    output logic            hflip,
    output logic            vflip,
    output logic [8:0]      hpos,
    output logic [3:0]      ysub,
    output logic            dr_start,
    input  logic            dr_busy,
    output logic            done,
    output logic            ovf
);

    localparam int ZW = (ZFRAC + 1 > 6) ? ZFRAC + 1 : 6;
    localparam int PW = 10 + ZW;

    if (MAXSPR < 1) begin : g_bad_maxspr
        $error("MAXSPR must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, FETCH, CHECK, DRAW, NEXT} state_t;

    state_t          st;
    logic [OBJW-1:0] obj;
    logic [2:0]      widx;
    logic [8:0]      vlatch;
    logic [14:0]     w0;
    logic [15:0]     w1, w2;
    logic [8:0]      xpos;
    logic [3:0]      col;
    logic [9:0]      ydiff_r;

    logic            vf, hf;
    logic [1:0]      vsz, hsz;
    assign vf  = w0[14];
    assign hf  = w0[13];
    assign vsz = w0[12:11];
    assign hsz = w0[10:9];

    // Vertical zone test and zoomed row offset
    logic [9:0]    dy, ydiff_c, hgt;
    logic [ZW-1:0] z;
    logic [PW-1:0] prod, scaled;
    logic          fits, inzone_c;

    assign dy       = {1'b0, vlatch} - w2[9:0];
    assign z        = (w2[15:10] == 6'd0) ? ZW'(1 << ZFRAC) : ZW'(w2[15:10]);
    assign prod     = PW'(dy) * PW'(z);
    assign scaled   = prod >> ZFRAC;
    assign fits     = (scaled >> 10) == '0;
    assign ydiff_c  = scaled[9:0];
    assign hgt      = 10'd16 << vsz;
    assign inzone_c = !dy[9] && fits && (ydiff_c < hgt);

    // Tile fields; in CHECK the first tile is built from the unregistered ydiff
    logic [9:0]  ysrc;
    logic [3:0]  wdt, ccol, col_eff;
    logic [5:0]  rmask, row_eff;
    logic [15:0] t_code;
    logic [8:0]  t_hpos;
    logic [3:0]  t_ysub;
    logic        draw_end, can_issue, issue, lim_hit;

    assign ysrc      = (st == CHECK) ? ydiff_c : ydiff_r;
    assign wdt       = 4'd1 << hsz;
    assign ccol      = (st == CHECK) ? 4'd0 : col;
    assign col_eff   = hf ? (wdt - 4'd1 - ccol) : ccol;
    assign rmask     = (6'd1 << vsz) - 6'd1;
    assign row_eff   = vf ? (ysrc[9:4] ^ rmask) : ysrc[9:4];
    assign t_code    = w1 + {7'd0, row_eff, 3'd0} + {12'd0, col_eff};
    assign t_hpos    = xpos + {1'b0, ccol, 4'd0};
    assign t_ysub    = ysrc[3:0] ^ {4{vf}};
    assign draw_end  = (st == DRAW) && (col == wdt);
    assign can_issue = !dr_busy && !dr_start;
    assign issue     = can_issue && (((st == CHECK) && inzone_c) || ((st == DRAW) && (col != wdt)));

`ifdef JTOBJ_SCAN_LIMIT_EN
    localparam int CW = $clog2(MAXSPR + 1);
    logic [CW-1:0] cnt;

    assign lim_hit = (cnt >= CW'(MAXSPR));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (cen) begin
            if (line_start) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                if (st == CHECK && inzone_c) cnt <= cnt + CW'(1);
                if (draw_end && lim_hit) ovf <= 1'b1;
            end
        end
    end
`else
    assign lim_hit = 1'b0;
    assign ovf     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            obj      <= '0;
            widx     <= '0;
            vlatch   <= '0;
            w0       <= '0;
            w1       <= '0;
            w2       <= '0;
            xpos     <= '0;
            col      <= '0;
            ydiff_r  <= '0;
            tbl_addr <= '0;
            code     <= '0;
            attr     <= '0;
            hflip    <= 1'b0;
            vflip    <= 1'b0;
            hpos     <= '0;
            ysub     <= '0;
            dr_start <= 1'b0;
            done     <= 1'b1;
        end else if (cen) begin
            dr_start <= 1'b0;
            if (!line_start && issue) begin
                code     <= t_code;
                attr     <= w0[8:0];
                hflip    <= hf;
                vflip    <= vf;
                hpos     <= t_hpos;
                ysub     <= t_ysub;
                dr_start <= 1'b1;
            end
            if (line_start) begin
                st       <= FETCH;
                obj      <= '0;
                widx     <= '0;
                vlatch   <= vrender;
                tbl_addr <= '0;
                done     <= 1'b0;
            end else begin
                case (st)
                    IDLE: ;
                    FETCH: begin
                        // Data for the word addressed last cycle arrives now
                        widx <= widx + 3'd1;
                        case (widx)
                            3'd0: tbl_addr <= {obj, 2'd1};
                            3'd1: begin
                                w0       <= tbl_data[14:0];
                                tbl_addr <= {obj, 2'd2};
                                if (!tbl_data[15]) st <= NEXT;
                            end
                            3'd2: begin
                                w1       <= tbl_data;
                                tbl_addr <= {obj, 2'd3};
                            end
                            3'd3: w2 <= tbl_data;
                            default: begin
                                xpos <= tbl_data[8:0];
                                st   <= CHECK;
                            end
                        endcase
                    end
                    CHECK: begin
                        ydiff_r <= ydiff_c;
                        col     <= issue ? 4'd1 : 4'd0;
                        st      <= inzone_c ? DRAW : NEXT;
                    end
                    DRAW: begin
                        if (draw_end) begin
                            if (lim_hit) begin
                                st   <= IDLE;
                                done <= 1'b1;
                            end else begin
                                st <= NEXT;
                            end
                        end else if (issue) begin
                            col <= col + 4'd1;
                        end
                    end
                    NEXT: begin
                        widx <= '0;
                        if (&obj) begin
                            st   <= IDLE;
                            done <= 1'b1;
                        end else begin
                            obj      <= obj + 1'b1;
                            tbl_addr <= {obj + 1'b1, 2'd0};
                            st       <= FETCH;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtobj_scan.sv
// Directed bench for jtobj_scan: table model, drawer with programmable busy time, tile checks.
module tb_jtobj_scan;
    localparam int OBJW   = 4;
    localparam int MAXSPR = 2;
    localparam int ZFRAC  = 5;
    localparam int NOBJ   = 1 << OBJW;

    logic            clk = 1'b0, rst = 1'b1, cen = 1'b1, line_start = 1'b0;
    logic [8:0]      vrender = '0;
    logic [OBJW+1:0] tbl_addr;
    logic [15:0]     tbl_data = '0;
    logic [15:0]     code;
    logic [8:0]      attr, hpos;
    logic            hflip, vflip, dr_start, done, ovf;
    logic [3:0]      ysub;
    logic            dr_busy = 1'b0;

    jtobj_scan #(.OBJW(OBJW), .MAXSPR(MAXSPR), .ZFRAC(ZFRAC)) dut (
        .clk(clk), .rst(rst), .cen(cen), .line_start(line_start), .vrender(vrender),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .code(code), .attr(attr),
        .hflip(hflip), .vflip(vflip), .hpos(hpos), .ysub(ysub),
        .dr_start(dr_start), .dr_busy(dr_busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:4*NOBJ-1];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (cen) tbl_data <= mem[tbl_addr];

    typedef struct {
        logic [15:0] code;
        logic [8:0]  hpos;
        logic [3:0]  ysub;
        logic        hf, vf;
        logic [8:0]  attr;
        int          cyc;
    } pulse_t;
    pulse_t pulses[$];

    int checks = 0, passes = 0, fails = 0;
    int busy_len = 1, bcnt = 0, changes = 0, dbl = 0, ls_cyc = 0;
    logic prev_start = 1'b0;
    logic [39:0] last_out = '0, cur_out;
    assign cur_out = {code, attr, hflip, vflip, hpos, ysub};

    // Drawer model: record each request, hold busy for busy_len cycles afterwards
    always @(negedge clk) begin
        pulse_t p;
        if (dr_start) begin
            p.code = code; p.hpos = hpos; p.ysub = ysub; p.hf = hflip; p.vf = vflip;
            p.attr = attr; p.cyc = cyc;
            pulses.push_back(p);
            if (prev_start) dbl++;
            bcnt = busy_len;
        end else begin
            if (!rst && cur_out !== last_out) changes++;
            if (bcnt > 0) bcnt--;
        end
        dr_busy = (bcnt > 0);
        last_out = cur_out;
        prev_start = dr_start;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pulse(input string tag, input int i, input logic [15:0] c,
                             input logic [8:0] hp, input logic [3:0] ys, input logic hf, input logic vf);
        if (i >= pulses.size()) chk({tag, " missing"}, pulses.size(), i + 1);
        else begin
            chk({tag, " code"}, pulses[i].code, c);
            chk({tag, " hpos"}, pulses[i].hpos, hp);
            chk({tag, " ysub"}, pulses[i].ysub, ys);
            chk({tag, " flips"}, {pulses[i].hf, pulses[i].vf}, {hf, vf});
        end
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 4 * NOBJ; i++) mem[i] = '0;
    endtask

    task automatic set_obj(input int o, input logic [15:0] a, b, c, d);
        mem[4*o] = a; mem[4*o+1] = b; mem[4*o+2] = c; mem[4*o+3] = d;
    endtask

    task automatic start_line(input logic [8:0] vr);
        pulses.delete();
        vrender = vr;
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        ls_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " done"}, done, 1'b1);
    endtask

    initial begin
        int n;
        clear_tbl();
        repeat (3) @(posedge clk);
        #1;
        chk("rst tbl_addr", tbl_addr, 0);
        chk("rst tile", {code, attr, hflip, vflip, hpos, ysub}, 0);
        chk("rst dr_start", dr_start, 0);
        chk("rst done", done, 1);
        chk("rst ovf", ovf, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All objects disabled: 3 cycles each
        start_line(9'h105);
        chk("busy after start", done, 0);
        wait_done("disabled", n);
        chk("disabled scan length", n, 3 * NOBJ);
        chk("disabled pulses", pulses.size(), 0);
        chk("disabled ovf", ovf, 0);

        // Two-tile object, no flips
        set_obj(0, 16'h82A5, 16'h0100, 16'h0100, 16'h0040);
        start_line(9'h105);
        wait_done("plain", n);
        chk("plain pulses", pulses.size(), 2);
        chk_pulse("plain t0", 0, 16'h0100, 9'h040, 4'h5, 1'b0, 1'b0);
        chk_pulse("plain t1", 1, 16'h0101, 9'h050, 4'h5, 1'b0, 1'b0);
        if (pulses.size() == 2) begin
            chk("plain attr", pulses[0].attr, 9'h0A5);
            chk("first tile latency", pulses[0].cyc - ls_cyc, 6);
            chk("tile spacing", pulses[1].cyc - pulses[0].cyc, 2);
        end

        // Same object flipped both ways
        set_obj(0, 16'hE2A5, 16'h0100, 16'h0100, 16'h0040);
        start_line(9'h105);
        wait_done("flip", n);
        chk("flip pulses", pulses.size(), 2);
        chk_pulse("flip t0", 0, 16'h0101, 9'h040, 4'hA, 1'b1, 1'b1);
        chk_pulse("flip t1", 1, 16'h0100, 9'h050, 4'hA, 1'b1, 1'b1);

        // Half zoom: last in-zone line, first line past, line above
        set_obj(0, 16'h8011, 16'h0200, 16'h4100, 16'h01F0);
        start_line(9'h11F);
        wait_done("zoom in", n);
        chk("zoom in pulses", pulses.size(), 1);
        chk_pulse("zoom in", 0, 16'h0200, 9'h1F0, 4'hF, 1'b0, 1'b0);
        start_line(9'h120);
        wait_done("zoom out", n);
        chk("zoom out pulses", pulses.size(), 0);
        start_line(9'h0FF);
        wait_done("above", n);
        chk("above pulses", pulses.size(), 0);

        // Two-row object: second row, hpos wraps at 9 bits
        set_obj(0, 16'h8A00, 16'h0300, 16'h0100, 16'h01F8);
        start_line(9'h115);
        wait_done("row1", n);
        chk("row1 pulses", pulses.size(), 2);
        chk_pulse("row1 t0", 0, 16'h0308, 9'h1F8, 4'h5, 1'b0, 1'b0);
        chk_pulse("row1 t1", 1, 16'h0309, 9'h008, 4'h5, 1'b0, 1'b0);

        // Long drawer busy between the two tiles
        set_obj(0, 16'h82A5, 16'h0100, 16'h0100, 16'h0040);
        busy_len = 10;
        start_line(9'h105);
        wait_done("busy", n);
        chk("busy pulses", pulses.size(), 2);
        if (pulses.size() == 2) chk("busy gap", pulses[1].cyc - pulses[0].cyc, 11);
        chk_pulse("busy t1", 1, 16'h0101, 9'h050, 4'h5, 1'b0, 1'b0);
        busy_len = 1;

        // Three single-tile in-zone objects
        clear_tbl();
        for (int k = 0; k < 3; k++) set_obj(k, 16'h8000, 16'(k * 16), 16'h0100, 16'h0000);
        start_line(9'h105);
        wait_done("limit", n);
`ifdef JTOBJ_SCAN_LIMIT_EN
        chk("limit pulses", pulses.size(), 2);
        chk("limit ovf", ovf, 1);
`else
        chk("nolimit pulses", pulses.size(), 3);
        chk_pulse("nolimit t2", 2, 16'h0020, 9'h000, 4'h5, 1'b0, 1'b0);
        chk("nolimit ovf", ovf, 0);
`endif
        chk_pulse("limit t1", 1, 16'h0010, 9'h000, 4'h5, 1'b0, 1'b0);

        // Restart while obj 1 waits on a busy drawer
        busy_len = 20;
        start_line(9'h105);
        chk("restart ovf clear", ovf, 0);
        n = 0;
        while (pulses.size() == 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("restart first pulse", pulses.size(), 1);
        repeat (12) @(posedge clk);
        #1;
        chk("no second pulse yet", pulses.size(), 1);
        start_line(9'h105);
        wait_done("restart", n);
        chk_pulse("restart t0", 0, 16'h0000, 9'h000, 4'h5, 1'b0, 1'b0);
`ifdef JTOBJ_SCAN_LIMIT_EN
        chk("restart pulses", pulses.size(), 2);
        chk("restart ovf", ovf, 1);
`else
        chk("restart pulses", pulses.size(), 3);
        chk("restart ovf", ovf, 0);
`endif
        chk("tile hold", changes, 0);
        chk("single-cycle start", dbl, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/jtobj_scan.md
# jtobj_scan

Parametrised per-line sprite table scanner, the generalised successor of the 053244 scan engine. On each line start it walks an external object table, keeps the objects that intersect the rendered line, applies vertical zoom, and splits each visible object into 16-pixel tiles. Tiles are handed to the line-buffer drawer through a start/busy handshake. Object count, sizes and the per-line sprite budget are parametrised.

## Interface
Parameters
- OBJW, 8, object index width; the table holds 2^OBJW objects.
- MAXSPR, 32, maximum in-zone objects drawn per line (only with the limit feature).
- ZFRAC, 5, zoom fraction bits; a zoom value of 2^ZFRAC is 1x.

Ports
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- cen  in  1  clock enable; all state advances only when cen=1
- line_start  in  1  one-cen pulse that starts a scan
- vrender  in  9  line to render, sampled on line_start
- tbl_addr  out  OBJW+2  table word address {obj, word[1:0]}
- tbl_data  in  16  table data, valid one cen cycle after tbl_addr
- code  out  16  tile code
- attr  out  9  attribute (W0[8:0])
- hflip, vflip  out  1  tile flips
- hpos  out  9  tile left pixel
- ysub  out  4  row inside tile
- dr_start  out  1  one-cen draw request
- dr_busy  in  1  drawer busy
- done  out  1  scan finished for this line
- ovf  out  1  per-line sprite limit reached

## Operation
Entry layout (4 words):
- W0 = {en, vf, hf, vsz[1:0], hsz[1:0], attr[8:0]}
- W1 = code
- W2 = {vzoom[5:0], y[9:0]}
- W3 = x[9:0]

Size and position arithmetic:
- Width = 1<<hsz tiles; height = 16<<vsz lines.
- z = (vzoom==0) ? 2^ZFRAC : vzoom.
- dy = {1'b0, vlatch} − y, 10-bit modulo 1024. ydiff = (dy*z)>>ZFRAC, 10 bits.
- In-zone when dy[9]==0, (dy*z)>>ZFRAC fits in 10 bits, and ydiff < (16<<vsz).

Tile generation:
- row = ydiff>>4, inverted within (1<<vsz) rows when vf=1.
- Tile col c = 0..width−1, issued in order. col_eff = vf-independent; when hf=1, col_eff = width−1−c.
- code = W1 + row*8 + col_eff, 16-bit wrap.
- hpos = x[8:0] + 16*c, 9-bit wrap. ysub = ydiff[3:0] ^ {4{vf}}.

States:
- IDLE: done=1. Left on line_start.
- FETCH: issue W0..W3. If W0.en=0, go to NEXT right after W0 data arrives.
- CHECK: one cycle to register ydiff and inzone. Out-of-zone → NEXT.
- DRAW: when dr_busy=0 and dr_start was not asserted last cycle, present tile outputs and pulse dr_start. After the last column → NEXT.
- NEXT: obj+1. After obj 2^OBJW−1 → IDLE.

Boundary conditions:
- line_start in any state aborts the current object, clears ovf, latches vrender, restarts at obj 0. dr_start is not asserted in that cycle.
- Tile outputs hold their value between dr_start pulses.

## Timing
- Reset values: tbl_addr=0, code=0, attr=0, hflip=0, vflip=0, hpos=0, ysub=0, dr_start=0, done=1, ovf=0, state IDLE.
- Cycle counts below are in cen cycles.
- Disabled object: 3 cycles (W0 addr, W0 data, NEXT).
- Out-of-zone object: 7 cycles (4 fetch, 1 last data, CHECK, NEXT).
- In-zone object: first dr_start in the cycle after CHECK if dr_busy=0. Each further tile is at least 2 cycles later.
- Handshake: dr_start is high for exactly one cycle. The drawer raises dr_busy no later than the cycle after dr_start. The scanner does not sample dr_busy in the cycle that follows dr_start.

## Configuration
- JTOBJ_SCAN_LIMIT_EN defined:
  - An in-zone counter increments in CHECK.
  - When it reaches MAXSPR, the object currently drawing completes, then ovf=1 and the state goes to IDLE for the rest of the line.
- Undefined: no counter, ovf tied 0, the whole table is always scanned.

## Test plan
- Reset, then line_start with an all-disabled table → done rises 3·2^OBJW+1 cycles later; no dr_start; ovf=0.
- Obj 0: y=0x100, hsz=1, vsz=0, x=0x40, code=0x100, vzoom=0. vrender=0x105 → two dr_start pulses: hpos 0x40, code 0x100; then hpos 0x50, code 0x101; ysub=5.
- Same object with hf=1, vf=1 → codes 0x101 then 0x100; ysub=0xA; vflip=hflip=1.
- vzoom=16 (0.5x), vsz=0, y=0x100: vrender 0x11F is in-zone with ysub=0xF; vrender 0x120 is out of zone.
- dr_busy held high 10 cycles after the first dr_start → the second pulse appears only after busy falls; tile outputs are stable meanwhile.
- With JTOBJ_SCAN_LIMIT_EN and MAXSPR=2, three in-zone 1-tile objects → 2 dr_start pulses, ovf=1. A line_start mid-draw clears ovf and restarts at obj 0.
